digit_entry: RTL and testbench
==============================

# digit_entry

Player-side input capture for the memorization game: collects four decimal digits from the board switches, one per debounced press of the enter button, and packs them into a 16-bit word in the same nibble layout as the generated sequence. Sits between the raw board buttons/switches and the answer comparator. Presents the finished word with a one-cycle valid pulse and holds it until the next round starts.

## Interface
- NUM_DIGITS, 4, digits per entry; user_int width is 4*NUM_DIGITS
- MAX_DIGIT, 9, largest accepted digit value
- DEBOUNCE_CYCLES, 250000, consecutive stable synchronized samples that qualify a button press
- TIMEOUT_CYCLES, 500000000, idle cycles in COLLECT before abandoning entry (used only with ENTRY_TIMEOUT_EN)

Ports:
- clk  in  1  system clock; the only clock
- rst  in  1  reset; synchronous, active-high
- start  in  1  single-cycle pulse: begin a new entry
- digit_sw  in  4  digit value from the switches, sampled when a press is qualified
- enter_btn  in  1  raw, asynchronous enter button
- clear_btn  in  1  raw, asynchronous clear button
- user_int  out  16  entered digits; entry k (0-based) at bits [4k+3:4k]
- digit_count  out  3  digits accepted so far, 0..4
- busy  out  1  high while in COLLECT
- entry_valid  out  1  one-cycle pulse: user_int complete
- reject  out  1  one-cycle pulse: qualified press with digit_sw > MAX_DIGIT
- timeout  out  1  one-cycle pulse: entry abandoned (always 0 without ENTRY_TIMEOUT_EN)

## Operation
- States: IDLE, COLLECT, DONE.
- Reset: state IDLE; user_int 0; digit_count 0; busy, entry_valid, reject, timeout 0; debounce state cleared.
- IDLE: presses ignored. On start: clear user_int and digit_count, go to COLLECT.
- COLLECT, qualified enter press:
  - If digit_sw ≤ MAX_DIGIT: write digit_sw to nibble digit_count, then increment digit_count.
  - Otherwise: pulse reject; nothing else changes.
  - The 4th accepted digit moves the FSM to DONE and pulses entry_valid.
- COLLECT, qualified clear press: user_int to 0, digit_count to 0, stay in COLLECT.
- DONE: user_int and digit_count (4) hold; presses ignored. On start: clear and go to COLLECT.
- Simultaneous events:
  - start beats everything.
  - clear beats enter in the same cycle.
  - start in COLLECT restarts the entry: clear and stay in COLLECT.
- rst mid-entry: returns to the reset state on the next edge; a press in progress must be re-qualified.
- Values: digit_sw is used unchanged as 4 bits; no arithmetic on digits.

## Timing
- Each raw button passes a 2-flop synchronizer, then a debounce counter.
- Press qualification: the synchronized level must stay high for DEBOUNCE_CYCLES consecutive cycles. The counter restarts on any low sample.
- Qualified press: exactly one pulse per press; no repeat while held. Re-arms only after the synchronized level has been low for DEBOUNCE_CYCLES cycles.
- Latency:
  - Raw high first sampled at edge N gives a press pulse at edge N+2+DEBOUNCE_CYCLES.
  - user_int, digit_count and reject update at the following edge.
- entry_valid asserts in the same cycle digit_count first reads 4 and state reads DONE.
- busy is registered and equals (state == COLLECT).

## Configuration
- ENTRY_TIMEOUT_EN defined:
  - Idle counter runs in COLLECT. It restarts on start, on each accepted digit, on reject and on clear.
  - On reaching TIMEOUT_CYCLES: pulse timeout, clear user_int and digit_count, go to IDLE.
  - The counter is held at 0 outside COLLECT.
- ENTRY_TIMEOUT_EN undefined: no idle counter; timeout tied to 0; COLLECT waits indefinitely.

## Structure
- Shared game package/include holds:
  - DIGIT_W = 4, NUM_DIGITS = 4, MAX_DIGIT = 9
  - state encodings IDLE/COLLECT/DONE
  - the nibble-packing convention; the comparator and sequence generator use the same definition.
- One sub-module, btn_debounce (synchronizer + counter + single-pulse output, parameter DEBOUNCE_CYCLES), instantiated twice: enter and clear.

## Test plan
Bench sets DEBOUNCE_CYCLES = 4 and TIMEOUT_CYCLES = 50.
- After reset: start, then enter digits 3,0,9,1 with clean presses → user_int = 16'h1903, digit_count = 4, entry_valid high exactly one cycle, busy 0.
- Press with digit_sw = 4'hC after two accepted digits → reject pulse; user_int and digit_count unchanged; later 7,2 → completes with 7 in nibble 2.
- Bouncing enter (high 2 cycles, low 1, high 10) → exactly one digit accepted; a press held 100 cycles → one digit.
- Clear after digits 5,5; then 1,2,3,4 → user_int = 16'h4321. Clear and enter qualified in the same cycle → digit_count = 0.
- Start issued in DONE and in mid-COLLECT → user_int = 0, digit_count = 0, busy = 1. rst asserted mid-entry → all outputs at reset values.
- ENTRY_TIMEOUT_EN: one digit accepted, then 50 idle cycles → timeout pulse, state IDLE, user_int = 0. Without the macro, the same stimulus leaves COLLECT held and timeout = 0.

Source files
------------

// File: rtl/digit_entry_pkg.sv
// Shared game definitions: digit geometry, entry FSM encoding and the nibble
// packing used by the sequence generator, the answer comparator and digit entry.
package digit_entry_pkg;

   localparam int DIGIT_W    = 4;
   localparam int NUM_DIGITS = 4;
   localparam int MAX_DIGIT  = 9;
   localparam int USER_W     = DIGIT_W * NUM_DIGITS;
   localparam int CNT_W      = $clog2(NUM_DIGITS + 1);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_DONE    = 2'd2
   } entry_state_t;

   // Digit k of a round lives in bits [DIGIT_W*k +: DIGIT_W]
   function automatic logic [USER_W-1:0] pack_digit(
      input logic [USER_W-1:0]  word,
      input logic [CNT_W-1:0]   idx,
      input logic [DIGIT_W-1:0] digit
   );
      logic [USER_W-1:0] w_word;
      w_word = word;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         w_word[i*DIGIT_W +: DIGIT_W] = (idx == CNT_W'(i)) ? digit
                                                            : w_word[i*DIGIT_W +: DIGIT_W];
      end
      return w_word;
   endfunction

endpackage

// File: rtl/digit_entry_btn_debounce.sv
// Raw button conditioning: 2-flop synchronizer, symmetric debounce counter and
// a single-cycle pulse on each qualified press (no repeat while held).
module btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 250000
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_btn,
   output logic o_press
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

   logic          r_sync1;
   logic          r_sync2;
   logic          r_level;
   logic          r_press;
   logic [CW-1:0] r_cnt;

   // r_cnt counts consecutive samples disagreeing with the debounced level;
   // once it reaches DEBOUNCE_CYCLES the level flips, and a rising flip pulses.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_level <= 1'b0;
         r_press <= 1'b0;
         r_cnt   <= {CW{1'b0}};
      end else begin
         r_sync1 <= i_btn;
         r_sync2 <= r_sync1;
         if (r_cnt == CW'(DEBOUNCE_CYCLES)) begin
            r_level <= ~r_level;
            r_press <= ~r_level;
            r_cnt   <= {CW{1'b0}};
         end else if (r_sync2 != r_level) begin
            r_press <= 1'b0;
            r_cnt   <= r_cnt + 1'b1;
         end else begin
            r_press <= 1'b0;
            r_cnt   <= {CW{1'b0}};
         end
      end
   end

   assign o_press = r_press;

endmodule

// File: rtl/digit_entry.sv
// Player digit entry: four debounced enter presses packed into one word.
// Optional idle abandonment is compiled in with `define ENTRY_TIMEOUT_EN.
module digit_entry
   import digit_entry_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 250000
`ifdef ENTRY_TIMEOUT_EN
   , parameter int TIMEOUT_CYCLES = 500000000
`endif
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_start,
   input  logic [DIGIT_W-1:0] i_digit_sw,
   input  logic              i_enter_btn,
   input  logic              i_clear_btn,
   output logic [USER_W-1:0] o_user_int,
   output logic [CNT_W-1:0]  o_digit_count,
   output logic              o_busy,
   output logic              o_entry_valid,
   output logic              o_reject,
   output logic              o_timeout
);

   logic w_enter;
   logic w_clear;

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter_db (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_btn   (i_enter_btn),
      .o_press (w_enter)
   );

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear_db (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_btn   (i_clear_btn),
      .o_press (w_clear)
   );

   entry_state_t      r_state;
   logic [USER_W-1:0] r_user_int;
   logic [CNT_W-1:0]  r_count;
   logic              r_busy;
   logic              r_valid;
   logic              r_reject;
   logic              r_timeout;
`ifdef ENTRY_TIMEOUT_EN
   localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [IDLE_W-1:0] r_idle;
`endif

   // Priority inside COLLECT: start, then clear, then enter, then idle timeout
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state    <= ST_IDLE;
         r_user_int <= {USER_W{1'b0}};
         r_count    <= {CNT_W{1'b0}};
         r_busy     <= 1'b0;
         r_valid    <= 1'b0;
         r_reject   <= 1'b0;
         r_timeout  <= 1'b0;
`ifdef ENTRY_TIMEOUT_EN
         r_idle     <= {IDLE_W{1'b0}};
`endif
      end else begin
         r_valid   <= 1'b0;
         r_reject  <= 1'b0;
         r_timeout <= 1'b0;
         if (i_start) begin
            r_state    <= ST_COLLECT;
            r_user_int <= {USER_W{1'b0}};
            r_count    <= {CNT_W{1'b0}};
            r_busy     <= 1'b1;
`ifdef ENTRY_TIMEOUT_EN
            r_idle     <= {IDLE_W{1'b0}};
`endif
         end else begin
            case (r_state)
               ST_COLLECT: begin
                  if (w_clear) begin
                     r_user_int <= {USER_W{1'b0}};
                     r_count    <= {CNT_W{1'b0}};
`ifdef ENTRY_TIMEOUT_EN
                     r_idle     <= {IDLE_W{1'b0}};
`endif
                  end else if (w_enter) begin
`ifdef ENTRY_TIMEOUT_EN
                     r_idle <= {IDLE_W{1'b0}};
`endif
                     if (i_digit_sw <= DIGIT_W'(MAX_DIGIT)) begin
                        r_user_int <= pack_digit(r_user_int, r_count, i_digit_sw);
                        r_count    <= r_count + 1'b1;
                        if (r_count == CNT_W'(NUM_DIGITS - 1)) begin
                           r_state <= ST_DONE;
                           r_busy  <= 1'b0;
                           r_valid <= 1'b1;
                        end else begin
                           r_state <= ST_COLLECT;
                        end
                     end else begin
                        r_reject <= 1'b1;
                     end
                  end else begin
`ifdef ENTRY_TIMEOUT_EN
                     if (r_idle == IDLE_W'(TIMEOUT_CYCLES - 1)) begin
                        r_timeout  <= 1'b1;
                        r_user_int <= {USER_W{1'b0}};
                        r_count    <= {CNT_W{1'b0}};
                        r_state    <= ST_IDLE;
                        r_busy     <= 1'b0;
                        r_idle     <= {IDLE_W{1'b0}};
                     end else begin
                        r_idle <= r_idle + 1'b1;
                     end
`else
                     r_state <= ST_COLLECT;
`endif
                  end
               end
               ST_IDLE, ST_DONE: begin
                  r_busy <= 1'b0;
`ifdef ENTRY_TIMEOUT_EN
                  r_idle <= {IDLE_W{1'b0}};
`endif
               end
               default: begin
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign o_user_int    = r_user_int;
   assign o_digit_count = r_count;
   assign o_busy        = r_busy;
   assign o_entry_valid = r_valid;
   assign o_reject      = r_reject;
   assign o_timeout     = r_timeout;

endmodule

// File: tb/tb_digit_entry.sv
// Directed bench for digit_entry with DEBOUNCE_CYCLES = 4 and TIMEOUT_CYCLES = 50;
// expectations follow ENTRY_TIMEOUT_EN when it is defined.
module tb_digit_entry;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [3:0]  digit_sw = 4'd0;
   logic        enter_btn = 1'b0;
   logic        clear_btn = 1'b0;
   logic [15:0] user_int;
   logic [2:0]  digit_count;
   logic        busy;
   logic        entry_valid;
   logic        reject;
   logic        timeout;

   int n_checks = 0;
   int n_pass   = 0;
   int n_valid  = 0;
   int n_reject = 0;
   int n_tmo    = 0;

   always #5 clk = ~clk;

   digit_entry #(
      .DEBOUNCE_CYCLES(4)
`ifdef ENTRY_TIMEOUT_EN
      , .TIMEOUT_CYCLES(50)
`endif
   ) dut (
      .i_clk         (clk),
      .i_rst         (rst),
      .i_start       (start),
      .i_digit_sw    (digit_sw),
      .i_enter_btn   (enter_btn),
      .i_clear_btn   (clear_btn),
      .o_user_int    (user_int),
      .o_digit_count (digit_count),
      .o_busy        (busy),
      .o_entry_valid (entry_valid),
      .o_reject      (reject),
      .o_timeout     (timeout)
   );

   task automatic cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         if (entry_valid) n_valid++;
         if (reject)      n_reject++;
         if (timeout)     n_tmo++;
      end
   endtask

   task automatic clr_counts();
      n_valid = 0; n_reject = 0; n_tmo = 0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      cycles(1);
      start = 1'b0;
   endtask

   task automatic press(input logic [3:0] d, input int hi);
      digit_sw = d;
      enter_btn = 1'b1;
      cycles(hi);
      enter_btn = 1'b0;
      cycles(8);
   endtask

   task automatic press_clear();
      clear_btn = 1'b1;
      cycles(8);
      clear_btn = 1'b0;
      cycles(8);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      cycles(3);
      rst = 1'b0;
      n_checks++; if (user_int !== 16'h0000) $display("FAIL reset_user_int got %h want 0000", user_int); else n_pass++;
      n_checks++; if (digit_count !== 3'd0) $display("FAIL reset_count got %0d want 0", digit_count); else n_pass++;
      n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
      n_checks++; if ({entry_valid, reject, timeout} !== 3'b000) $display("FAIL reset_pulses got %b want 000", {entry_valid, reject, timeout}); else n_pass++;
      press(4'd5, 8);
      n_checks++; if (digit_count !== 3'd0) $display("FAIL idle_ignores_press got %0d want 0", digit_count); else n_pass++;
   endtask

   task automatic test_entry();
      clr_counts();
      pulse_start();
      n_checks++; if (busy !== 1'b1) $display("FAIL entry_busy got %b want 1", busy); else n_pass++;
      press(4'd3, 8); press(4'd0, 8); press(4'd9, 8); press(4'd1, 8);
      n_checks++; if (user_int !== 16'h1903) $display("FAIL entry_user_int got %h want 1903", user_int); else n_pass++;
      n_checks++; if (digit_count !== 3'd4) $display("FAIL entry_count got %0d want 4", digit_count); else n_pass++;
      n_checks++; if (n_valid !== 1) $display("FAIL entry_valid_pulses got %0d want 1", n_valid); else n_pass++;
      n_checks++; if (busy !== 1'b0) $display("FAIL entry_busy_done got %b want 0", busy); else n_pass++;
      press(4'd7, 8);
      n_checks++; if (user_int !== 16'h1903) $display("FAIL done_ignores_press got %h want 1903", user_int); else n_pass++;
   endtask

   task automatic test_reject();
      clr_counts();
      pulse_start();
      press(4'd6, 8); press(4'd8, 8); press(4'hC, 8);
      n_checks++; if (n_reject !== 1) $display("FAIL reject_pulses got %0d want 1", n_reject); else n_pass++;
      n_checks++; if (user_int !== 16'h0086) $display("FAIL reject_user_int got %h want 0086", user_int); else n_pass++;
      n_checks++; if (digit_count !== 3'd2) $display("FAIL reject_count got %0d want 2", digit_count); else n_pass++;
      press(4'd7, 8); press(4'd2, 8);
      n_checks++; if (user_int !== 16'h2786) $display("FAIL reject_complete got %h want 2786", user_int); else n_pass++;
      n_checks++; if (n_valid !== 1) $display("FAIL reject_valid got %0d want 1", n_valid); else n_pass++;
   endtask

   task automatic test_bounce();
      clr_counts();
      pulse_start();
      digit_sw = 4'd5;
      enter_btn = 1'b1; cycles(2);
      enter_btn = 1'b0; cycles(1);
      enter_btn = 1'b1; cycles(10);
      enter_btn = 1'b0; cycles(8);
      n_checks++; if (digit_count !== 3'd1) $display("FAIL bounce_count got %0d want 1", digit_count); else n_pass++;
      press(4'd6, 8); press(4'd7, 8);
      press(4'd8, 100);
      n_checks++; if (digit_count !== 3'd4) $display("FAIL held_count got %0d want 4", digit_count); else n_pass++;
      n_checks++; if (user_int !== 16'h8765) $display("FAIL held_user_int got %h want 8765", user_int); else n_pass++;
      n_checks++; if (n_valid !== 1) $display("FAIL held_valid got %0d want 1", n_valid); else n_pass++;
   endtask

   task automatic test_clear();
      clr_counts();
      pulse_start();
      press(4'd5, 8); press(4'd5, 8);
      press_clear();
      n_checks++; if (digit_count !== 3'd0) $display("FAIL clear_count got %0d want 0", digit_count); else n_pass++;
      n_checks++; if (user_int !== 16'h0000) $display("FAIL clear_user_int got %h want 0000", user_int); else n_pass++;
      press(4'd1, 8); press(4'd2, 8); press(4'd3, 8); press(4'd4, 8);
      n_checks++; if (user_int !== 16'h4321) $display("FAIL clear_then_entry got %h want 4321", user_int); else n_pass++;
      pulse_start();
      press(4'd8, 8);
      n_checks++; if (digit_count !== 3'd1) $display("FAIL pre_simul_count got %0d want 1", digit_count); else n_pass++;
      digit_sw = 4'd2;
      enter_btn = 1'b1; clear_btn = 1'b1;
      cycles(8);
      enter_btn = 1'b0; clear_btn = 1'b0;
      cycles(8);
      n_checks++; if (digit_count !== 3'd0) $display("FAIL simul_clear_count got %0d want 0", digit_count); else n_pass++;
      n_checks++; if (user_int !== 16'h0000) $display("FAIL simul_clear_user_int got %h want 0000", user_int); else n_pass++;
   endtask

   task automatic test_start_rst();
      press(4'd1, 8); press(4'd2, 8); press(4'd3, 8); press(4'd4, 8);
      n_checks++; if (busy !== 1'b0) $display("FAIL restart_pre_done got busy %b want 0", busy); else n_pass++;
      pulse_start();
      n_checks++; if ({user_int, digit_count, busy} !== {16'h0000, 3'd0, 1'b1}) $display("FAIL start_in_done got %h/%0d/%b want 0000/0/1", user_int, digit_count, busy); else n_pass++;
      press(4'd7, 8);
      n_checks++; if (digit_count !== 3'd1) $display("FAIL mid_collect_count got %0d want 1", digit_count); else n_pass++;
      pulse_start();
      n_checks++; if ({user_int, digit_count, busy} !== {16'h0000, 3'd0, 1'b1}) $display("FAIL start_in_collect got %h/%0d/%b want 0000/0/1", user_int, digit_count, busy); else n_pass++;
      press(4'd9, 8);
      digit_sw = 4'd6;
      enter_btn = 1'b1;
      cycles(3);
      rst = 1'b1;
      cycles(1);
      n_checks++; if ({user_int, digit_count, busy, entry_valid, reject, timeout} !== 24'h0) $display("FAIL rst_mid_entry got %h/%0d/%b%b%b%b want all 0", user_int, digit_count, busy, entry_valid, reject, timeout); else n_pass++;
      rst = 1'b0;
      cycles(10);
      enter_btn = 1'b0;
      cycles(8);
      n_checks++; if (digit_count !== 3'd0) $display("FAIL after_rst_idle got %0d want 0", digit_count); else n_pass++;
   endtask

   task automatic test_timeout();
      clr_counts();
      pulse_start();
      press(4'd3, 8);
      cycles(60);
`ifdef ENTRY_TIMEOUT_EN
      n_checks++; if (n_tmo !== 1) $display("FAIL timeout_pulses got %0d want 1", n_tmo); else n_pass++;
      n_checks++; if (busy !== 1'b0) $display("FAIL timeout_busy got %b want 0", busy); else n_pass++;
      n_checks++; if (user_int !== 16'h0000) $display("FAIL timeout_user_int got %h want 0000", user_int); else n_pass++;
      n_checks++; if (digit_count !== 3'd0) $display("FAIL timeout_count got %0d want 0", digit_count); else n_pass++;
`else
      n_checks++; if (n_tmo !== 0) $display("FAIL timeout_pulses got %0d want 0", n_tmo); else n_pass++;
      n_checks++; if (busy !== 1'b1) $display("FAIL timeout_busy got %b want 1", busy); else n_pass++;
      n_checks++; if (user_int !== 16'h0003) $display("FAIL timeout_user_int got %h want 0003", user_int); else n_pass++;
      n_checks++; if (digit_count !== 3'd1) $display("FAIL timeout_count got %0d want 1", digit_count); else n_pass++;
`endif
   endtask

   initial begin
      test_reset();
      test_entry();
      test_reject();
      test_bounce();
      test_clear();
      test_start_rst();
      test_timeout();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
